// File: rtl/uart_tx_scheduler.sv
`timescale 1ns/1ps
// uart_tx_scheduler
//   Round-robin scheduler that shares one UART transmitter between N byte
//   requesters, and generates the baud tick used by both sides.
//   CLKIN/RESETN   : clock, asynchronous active-low reset
//   req_data       : N bytes, channel k in [8k+7:8k]
//   req_valid      : per-channel request, held until its req_ready pulse
//   req_ready      : one-cycle capture pulse per channel
//   tx_data        : registered byte to the transmitter, changes only in LOAD
//   tx_valid       : frame request to the transmitter
//   tx_ready       : accept from the transmitter (only honoured in SEND)
//   clock_enable   : baud tick, one cycle every CLK_DIV cycles
//   busy           : state is not IDLE
//   grant_id       : channel being served, holds last value when idle
module uart_tx_scheduler #(
  parameter int N          = 4,
  parameter int CLK_DIV    = 16,
  parameter int HOLD_TICKS = 10
) (
  input  logic                 CLKIN,
  input  logic                 RESETN,
  input  logic [N*8-1:0]       req_data,
  input  logic [N-1:0]         req_valid,
  output logic [N-1:0]         req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 clock_enable,
  output logic                 busy,
  output logic [$clog2(N)-1:0] grant_id
);

  localparam int          IW        = $clog2(N);
  localparam int          DW        = $clog2(CLK_DIV);
  localparam int          HW        = $clog2(HOLD_TICKS + 1);
  localparam int unsigned NU        = N;
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, HOLD} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] div_cnt;
  logic [HW-1:0] hold_cnt, hold_cnt_nxt;
  logic [IW-1:0] ptr, ptr_nxt, sel;
  logic          found;
  logic [7:0]    byte_sel;
  logic [7:0]    tx_data_nxt;
  logic          tx_valid_nxt;
  logic [N-1:0]  req_ready_nxt;

  // Free-running baud divider.
  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN)
      div_cnt <= '0;
    else if (div_cnt == DIV_LAST)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + 1'b1;
  end

  assign clock_enable = (div_cnt == DIV_LAST);

  // Round-robin search: first valid channel starting at ptr+1 (mod N).
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    byte_sel = '0;
    for (int unsigned i = 1; i <= NU; i++) begin
      for (int unsigned k = 0; k < NU; k++) begin
        if (!found && req_valid[k] && (k == (32'(ptr) + i) % NU)) begin
          found    = 1'b1;
          sel      = IW'(k);
          byte_sel = req_data[8*k +: 8];
        end
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    hold_cnt_nxt  = hold_cnt;
    tx_data_nxt   = tx_data;
    tx_valid_nxt  = tx_valid;
    req_ready_nxt = '0;
    case (state)
      IDLE: begin
        if (|req_valid)
          state_nxt = LOAD;
      end
      LOAD: begin
        // A request withdrawn between IDLE and LOAD simply returns to IDLE.
        if (found) begin
          tx_data_nxt   = byte_sel;
          ptr_nxt       = sel;
          req_ready_nxt = {{(N-1){1'b0}}, 1'b1} << sel;
          tx_valid_nxt  = 1'b1;
          state_nxt     = SEND;
        end else begin
          state_nxt = IDLE;
        end
      end
      SEND: begin
        if (tx_ready) begin
          tx_valid_nxt = 1'b0;
          hold_cnt_nxt = '0;
          state_nxt    = HOLD;
        end
      end
      HOLD: begin
        if (clock_enable) begin
          hold_cnt_nxt = hold_cnt + 1'b1;
          if (hold_cnt == HOLD_LAST)
            state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      req_ready <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      hold_cnt  <= hold_cnt_nxt;
      tx_data   <= tx_data_nxt;
      tx_valid  <= tx_valid_nxt;
      req_ready <= req_ready_nxt;
    end
  end

  // The round-robin pointer always equals the last granted channel.
  assign grant_id = ptr;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
`timescale 1ns/1ps
// Testbench for uart_tx_scheduler with a simple transmitter model that reads
// tx_data bit by bit on the baud tick and reassembles the frame from its line.
module tb_uart_tx_scheduler;

  localparam int N          = 4;
  localparam int CLK_DIV    = 4;
  localparam int HOLD_TICKS = 10;

  logic             CLKIN = 1'b0;
  logic             RESETN;
  logic [N*8-1:0]   req_data;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             clock_enable;
  logic             busy;
  logic [1:0]       grant_id;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [7:0] ch;
    logic [7:0] data;
  } exp_t;

  exp_t       gq[$];
  logic [7:0] fq[$];
  logic [7:0] rxq[$];

  uart_tx_scheduler #(
    .N          (N),
    .CLK_DIV    (CLK_DIV),
    .HOLD_TICKS (HOLD_TICKS)
  ) dut (
    .CLKIN        (CLKIN),
    .RESETN       (RESETN),
    .req_data     (req_data),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .clock_enable (clock_enable),
    .busy         (busy),
    .grant_id     (grant_id)
  );

  always #5 CLKIN = ~CLKIN;

  // Transmitter model: 0 idle, 1 start, 2..9 data bits 0..7, 10 stop.
  int         tstate;
  logic       line;
  logic [7:0] rx;

  assign tx_ready = (tstate == 0) && clock_enable;

  always @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      tstate <= 0;
      line   <= 1'b1;
      rx     <= '0;
    end else if (clock_enable) begin
      case (tstate)
        0: if (tx_valid) begin
             tstate <= 1;
             line   <= 1'b0;
           end
        1: begin
             tstate <= 2;
             line   <= tx_data[0];
           end
        10: begin
             rxq.push_back(rx);
             tstate <= 0;
           end
        default: begin
             rx[3'(tstate - 2)] <= line;
             if (tstate == 9)
               line <= 1'b1;
             else
               line <= tx_data[3'(tstate - 1)];
             tstate <= tstate + 1;
           end
      endcase
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int ch, input logic [7:0] d);
    exp_t e;
    req_data[ch*8 +: 8] = d;
    req_valid[ch]       = 1'b1;
    e.ch   = 8'(ch);
    e.data = d;
    gq.push_back(e);
    fq.push_back(d);
  endtask

  task automatic expect_grant(input bit keep);
    exp_t       e;
    logic [N-1:0] expv;
    int         n;
    e    = gq.pop_front();
    expv = '0;
    expv[e.ch] = 1'b1;
    n = 0;
    while (req_ready == '0 && n < 200) begin
      @(negedge CLKIN);
      n++;
    end
    check("grant_ready", req_ready, expv);
    check("grant_id", grant_id, e.ch);
    check("grant_data", tx_data, e.data);
    check("grant_valid", tx_valid, 1);
    if (!keep)
      req_valid[e.ch] = 1'b0;
    @(negedge CLKIN);
    check("ready_pulse_width", req_ready, 0);
  endtask

  task automatic expect_frame();
    logic [7:0] ex;
    logic [7:0] got;
    int         n;
    ex = fq.pop_front();
    n  = 0;
    while (rxq.size() == 0 && n < 400) begin
      @(negedge CLKIN);
      n++;
    end
    got = (rxq.size() > 0) ? rxq.pop_front() : 8'hxx;
    check("frame_byte", got, ex);
  endtask

  task automatic do_reset();
    RESETN    = 1'b0;
    req_valid = '0;
    @(negedge CLKIN);
    @(negedge CLKIN);
    RESETN = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ticks;
    int pulses;

    RESETN    = 1'b0;
    req_valid = '0;
    req_data  = '0;
    repeat (3) @(negedge CLKIN);
    check("reset_outputs", {req_ready, tx_data, tx_valid, clock_enable, busy, grant_id}, 0);
    RESETN = 1'b1;

    // Divider alone; transmitter ready pulses at idle ticks must be ignored.
    for (int c = 0; c < 24; c++) begin
      check("div_ce", clock_enable, (c % CLK_DIV) == CLK_DIV - 1);
      check("idle_busy", busy, 0);
      check("idle_valid", tx_valid, 0);
      @(negedge CLKIN);
    end

    // Single request on ch2.
    drive(2, 8'hA5);
    @(negedge CLKIN);
    check("lat1_ready", req_ready, 0);
    check("lat1_busy", busy, 1);
    @(negedge CLKIN);
    expect_grant(0);
    n = 0;
    while (tx_valid && n < 200) begin
      @(negedge CLKIN);
      n++;
    end
    ticks = 0;
    n = 0;
    while (busy && n < 400) begin
      if (clock_enable) ticks++;
      @(negedge CLKIN);
      n++;
    end
    check("hold_ticks", ticks, HOLD_TICKS);
    expect_frame();
    check("data_after_frame", tx_data, 8'hA5);

    // All four at once from pointer 0: order 1,2,3,0.
    do_reset();
    drive(1, 8'h22);
    drive(2, 8'h33);
    drive(3, 8'h44);
    drive(0, 8'h11);
    repeat (4) begin
      expect_grant(0);
      expect_frame();
    end
    pulses = 0;
    repeat (20) begin
      @(negedge CLKIN);
      if (req_ready != '0) pulses++;
    end
    check("extra_ready", pulses, 0);
    check("all_done_idle", busy, 0);

    // Fairness: ch0 keeps requesting, ch3 must win the next frame.
    do_reset();
    drive(0, 8'h0F);
    expect_grant(1);
    drive(3, 8'hC3);
    drive(0, 8'hF0);
    expect_frame();
    expect_grant(0);
    expect_frame();
    expect_grant(0);
    expect_frame();

    // Data stability while the source byte churns.
    do_reset();
    drive(1, 8'h96);
    expect_grant(0);
    n = 0;
    while (rxq.size() == 0 && n < 400) begin
      req_data[15:8] = 8'($urandom);
      check("hold_data", tx_data, 8'h96);
      @(negedge CLKIN);
      n++;
    end
    expect_frame();

    // Reset in the middle of data bit 4.
    do_reset();
    drive(2, 8'h5A);
    expect_grant(0);
    n = 0;
    while (tstate != 6 && n < 400) begin
      @(negedge CLKIN);
      n++;
    end
    check("reached_bit4", tstate, 6);
    RESETN = 1'b0;
    void'(fq.pop_front());
    #1;
    check("abort_outputs", {req_ready, tx_data, tx_valid, clock_enable, busy, grant_id}, 0);
    drive(1, 8'h3C);
    @(negedge CLKIN);
    @(negedge CLKIN);
    RESETN = 1'b1;
    check("restart_ce0", clock_enable, 0);
    check("restart_idle", busy, 0);
    @(negedge CLKIN);
    check("restart_ce1", clock_enable, 0);
    check("restart_load", busy, 1);
    @(negedge CLKIN);
    expect_grant(0);
    check("restart_ce3", clock_enable, 1);
    expect_frame();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one `uart_transmitter` between N byte requesters using round-robin arbitration.
- Generates the baud-rate `clock_enable` tick that the scheduler and the transmitter both use.
- Sequences each frame: presents the byte, waits for the transmitter's accept, then holds the byte stable until the last data bit has been shifted.
- Sits between the application byte sources and the transmitter instance.

Parameters:
- N, 4, number of requester channels (2..8).
- CLK_DIV, 16, CLKIN cycles per `clock_enable` tick (at least 2).
- HOLD_TICKS, 10, enable ticks to hold `tx_data` after the transmitter accepts the byte.

Ports:
- CLKIN  input  1  system clock; all logic on the rising edge.
- RESETN  input  1  asynchronous active-low reset.
- req_data  input  N*8  byte from channel k in bits [8k+7:8k].
- req_valid  input  N  channel k has a byte pending; held until its req_ready pulse.
- req_ready  output  N  one-cycle pulse to channel k when its byte is captured.
- tx_data  output  8  byte to the transmitter's data input; registered.
- tx_valid  output  1  to the transmitter's valid input.
- tx_ready  input  1  from the transmitter's ready output.
- clock_enable  output  1  baud tick; one CLKIN cycle high every CLK_DIV cycles.
- busy  output  1  high whenever the state is not IDLE.
- grant_id  output  clog2(N)  channel currently being served; holds last value in IDLE.

Behaviour:
- Reset values: every output, the divider count, the hold counter and the round-robin pointer are 0. The state is IDLE.
- RESETN low mid-frame aborts the frame immediately. No req_ready is re-issued for the captured byte, and that byte is lost.
- Divider:
  - Counts 0..CLK_DIV-1 and wraps to 0.
  - `clock_enable` is high in the cycle the count equals CLK_DIV-1.
  - The divider is free-running, independent of state.
- Round-robin:
  - The search starts at pointer+1 mod N and picks the first channel with req_valid high.
  - On each grant the pointer is set to the granted channel.
- State machine (transitions in any CLKIN cycle unless noted):
  - IDLE: if any req_valid is high, go to LOAD.
  - LOAD (1 cycle):
    - tx_data <= selected channel's byte; grant_id <= that channel.
    - Pulse that channel's req_ready bit; update the pointer.
    - Go to SEND.
  - SEND:
    - tx_valid = 1 and tx_data held.
    - When tx_ready = 1 is sampled: tx_valid <= 0, hold counter <= 0, go to HOLD.
  - HOLD:
    - tx_valid = 0 and tx_data held.
    - Increment the counter on each clock_enable.
    - When the counter reaches HOLD_TICKS with clock_enable high, go to IDLE.
- tx_data changes only in LOAD. It is stable from the accept tick through the stop-bit tick.
- A new request can win no earlier than one tick after the stop bit. tx_valid may be asserted while the transmitter is in its final state; the transmitter accepts at its next idle tick.
- Request latency: req_valid rising in IDLE gives req_ready 2 CLKIN cycles later (IDLE→LOAD, pulse in LOAD).
- Simultaneous requests: only one channel is granted per frame. Others remain pending, are not acknowledged, and are served in round-robin order.
- req_valid dropping before grant withdraws the request without error.
- req_valid dropping after req_ready has no effect; the byte is already captured.
- A channel that re-asserts immediately after its req_ready waits behind all other pending channels.
- tx_ready seen high outside SEND is ignored.

Test Plan:
- N=4, CLK_DIV=4, single request: ch2 sends 0xA5 in IDLE.
  - Required: req_ready[2] pulses 2 cycles later, tx_data=0xA5, tx_valid high until tx_ready.
  - Required: the line carries start, then 1,0,1,0,0,1,0,1 LSB-first, then stop; busy drops after HOLD_TICKS ticks.
- All four channels request together with pointer=0 (bytes 0x11, 0x22, 0x33, 0x44).
  - Required grant order 1,2,3,0; four back-to-back correct frames; each req_ready fires exactly once.
- Fairness: ch0 re-asserts immediately after every grant while ch3 is pending.
  - Required: ch3 is served before ch0's second frame.
- Data stability: change req_data for the granted channel every cycle after its req_ready.
  - Required: tx_data stays constant through HOLD and the transmitted bits match the captured byte.
- Reset mid-frame: assert RESETN low during HOLD bit 4.
  - Required: all outputs 0, state IDLE, divider restarts.
  - Required: after release, a pending ch1 request (0x3C) completes a clean frame.
- Divider: CLK_DIV=4 with no traffic.
  - Required: clock_enable high exactly every 4th cycle; busy stays 0; tx_valid never asserts.
